pr_avmm_freeze_bridge: RTL and testbench

Sits directly downstream of the PR user-logic wrapper's AVMM master port. It sits between that port and the static-region NoC AVMM slave.
- Passes transactions through in normal operation.
- On a freeze request, it stops new traffic and drains outstanding reads, then acknowledges so the sector can be reconfigured safely.
- Blocks all region-driven traffic while frozen, tracks read responses, and flags protocol errors.

---
 rtl/pr_bridge_pkg.sv | 18 +
 rtl/pr_outstanding_tracker.sv | 41 ++++
 rtl/pr_avmm_freeze_bridge.sv | 118 +++++++++++
 tb/tb_pr_avmm_freeze_bridge.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pr_bridge_pkg.sv
// Shared state encoding, default widths and counter sizing for the PR AVMM freeze bridge.
package pr_bridge_pkg;

  localparam int DEFAULT_ADDR_W = 20;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    FROZEN = 2'd2
  } bridge_state_t;

  // Bits needed to hold every value from 0 up to and including max_count.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/pr_outstanding_tracker.sv
// Saturating count of reads accepted by the NoC and still awaiting readdatavalid.
// Count updates one cycle after inc/dec; a dec seen at zero is reported as stray and ignored.
module pr_outstanding_tracker
  import pr_bridge_pkg::*;
#(
  parameter int MAX_COUNT = 8,
  parameter int CNT_W     = cnt_width(MAX_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             force_clr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             stray
);

  logic inc_eff;
  logic dec_eff;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(MAX_COUNT));
  assign stray = dec & empty;

  // A stray response must not cancel a genuinely accepted read in the same cycle.
  assign dec_eff = dec & ~empty;
  assign inc_eff = inc & (~full | dec_eff);

  always_ff @(posedge clk) begin
    if (rst || force_clr) begin
      count <= '0;
    end else if (inc_eff && !dec_eff) begin
      count <= count + CNT_W'(1);
    end else if (dec_eff && !inc_eff) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pr_avmm_freeze_bridge.sv
// Isolates a PR region's AVMM master from the static NoC: pass-through in RUN, drain then freeze on request.
// Zero-latency combinational data paths; region is stalled whenever the path is closed.
module pr_avmm_freeze_bridge
  import pr_bridge_pkg::*;
#(
  parameter int ADDR_W          = DEFAULT_ADDR_W,
  parameter int DATA_W          = DEFAULT_DATA_W,
  parameter int MAX_OUTSTANDING = 8,
  parameter int DRAIN_TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_address,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [DATA_W-1:0] s_writedata,
  output logic              s_waitrequest,
  output logic [DATA_W-1:0] s_readdata,
  output logic              s_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  input  logic              freeze_req,
  output logic              freeze_ack,
  output logic              timeout_err,
  output logic              stray_rdv_err
);

  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);
  localparam int TMO_W = $clog2(DRAIN_TIMEOUT);

  bridge_state_t    state;
  bridge_state_t    state_nxt;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             stray;
  logic [TMO_W-1:0] tmo_cnt;
  logic             open_path;
  logic             rd_acc;
  logic             drain_expired;
  logic             force_clr;

  assign m_address   = s_address;
  assign m_writedata = s_writedata;
  assign s_readdata  = m_readdata;

  // Writes never wait on read credits, so only reads are throttled by the outstanding limit.
  assign open_path     = (state == RUN) && (!full || s_write);
  assign m_read        = open_path & s_read;
  assign m_write       = open_path & s_write;
  assign s_waitrequest = open_path ? m_waitrequest : 1'b1;
  assign rd_acc        = m_read & ~m_waitrequest;

  assign s_readdatavalid = m_readdatavalid & ~empty;
  assign drain_expired   = (tmo_cnt == TMO_W'(DRAIN_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    force_clr = 1'b0;
    case (state)
      RUN: begin
        if (freeze_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!freeze_req) begin
          state_nxt = RUN;
        end else if (empty) begin
          state_nxt = FROZEN;
        end else if (drain_expired) begin
          // Give up on the missing responses; anything arriving later is treated as stray.
          state_nxt = FROZEN;
          force_clr = 1'b1;
        end
      end
      FROZEN: begin
        if (!freeze_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  pr_outstanding_tracker #(
    .MAX_COUNT (MAX_OUTSTANDING),
    .CNT_W     (CNT_W)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .inc       (rd_acc),
    .dec       (m_readdatavalid),
    .force_clr (force_clr),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .stray     (stray)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      tmo_cnt       <= '0;
      freeze_ack    <= 1'b0;
      timeout_err   <= 1'b0;
      stray_rdv_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      tmo_cnt       <= (state == DRAIN && state_nxt == DRAIN) ? tmo_cnt + TMO_W'(1) : '0;
      freeze_ack    <= (state_nxt == FROZEN);
      timeout_err   <= timeout_err | force_clr;
      stray_rdv_err <= stray_rdv_err | stray;
    end
  end

endmodule

// File: tb/tb_pr_avmm_freeze_bridge.sv
// Scoreboarded bench for pr_avmm_freeze_bridge: directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_pr_avmm_freeze_bridge;

  localparam int AW       = 20;
  localparam int DW       = 32;
  localparam int MAXO     = 8;
  localparam int TMO      = 16;
  localparam int S_RUN    = 0;
  localparam int S_DRAIN  = 1;
  localparam int S_FROZEN = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] s_address = '0;
  logic          s_read = 1'b0;
  logic          s_write = 1'b0;
  logic [DW-1:0] s_writedata = '0;
  logic          s_waitrequest;
  logic [DW-1:0] s_readdata;
  logic          s_readdatavalid;
  logic [AW-1:0] m_address;
  logic          m_read;
  logic          m_write;
  logic [DW-1:0] m_writedata;
  logic          m_waitrequest = 1'b0;
  logic [DW-1:0] m_readdata = '0;
  logic          m_readdatavalid = 1'b0;
  logic          freeze_req = 1'b0;
  logic          freeze_ack;
  logic          timeout_err;
  logic          stray_rdv_err;

  always #5 clk = ~clk;

  pr_avmm_freeze_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO), .DRAIN_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .freeze_req(freeze_req), .freeze_ack(freeze_ack),
    .timeout_err(timeout_err), .stray_rdv_err(stray_rdv_err)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Reference model: abstract bridge mode, number of reads owed to the region, sticky flags.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  int            st = S_RUN;
  int            outst = 0;
  int            drain_entry = 0;
  bit            terr = 1'b0;
  bit            serr = 1'b0;
  int            cyc = 0;
  rsp_t          noc_q[$];
  logic [DW-1:0] exp_q[$];
  bit            mon_en = 1'b0;
  bit            noc_hold = 1'b0;
  bit            use_fixed = 1'b0;
  logic [DW-1:0] fixed_data = '0;
  int            dly_min = 1;
  int            dly_max = 3;
  bit            stray_inject = 1'b0;

  initial begin : model
    bit            open_p;
    bit            rd_ok;
    bit            rsp;
    int            prev_outst;
    rsp_t          r;
    bit            nrdv;
    logic [DW-1:0] nd;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        st = S_RUN; outst = 0; terr = 1'b0; serr = 1'b0;
        noc_q.delete(); exp_q.delete();
      end else begin
        open_p = (st == S_RUN) && (outst < MAXO || s_write);
        rd_ok  = open_p && s_read && !m_waitrequest;
        rsp    = m_readdatavalid && (outst > 0);
        if (m_readdatavalid && outst == 0) serr = 1'b1;
        prev_outst = outst;
        if (rd_ok) begin
          r.data = use_fixed ? fixed_data : DW'($urandom());
          r.due  = cyc + int'($urandom_range(dly_max, dly_min));
          noc_q.push_back(r);
          exp_q.push_back(r.data);
        end
        outst = outst + (rd_ok ? 1 : 0) - (rsp ? 1 : 0);
        case (st)
          S_RUN: if (freeze_req) begin st = S_DRAIN; drain_entry = cyc; end
          S_DRAIN: begin
            if (!freeze_req) st = S_RUN;
            else if (prev_outst == 0) st = S_FROZEN;
            else if (cyc - drain_entry >= TMO) begin
              st = S_FROZEN; terr = 1'b1; outst = 0; exp_q.delete();
            end
          end
          default: if (!freeze_req) st = S_RUN;
        endcase
      end
      // NoC slave: in-order responses once due, unless withheld.
      if (!noc_hold && noc_q.size() > 0 && noc_q[0].due <= cyc) begin
        r = noc_q.pop_front();
        nrdv = 1'b1; nd = r.data;
      end else if (stray_inject && outst == 0 && !rst) begin
        nrdv = 1'b1; nd = DW'($urandom()); stray_inject = 1'b0;
      end else begin
        nrdv = 1'b0; nd = DW'($urandom());
      end
      #1;
      m_readdatavalid = nrdv;
      m_readdata      = nd;
    end
  end

  initial begin : monitor
    bit            open_p;
    logic [DW-1:0] exp_d;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        open_p = (st == S_RUN) && (outst < MAXO || s_write);
        check("m_read", 64'(m_read), 64'(open_p && s_read));
        check("m_write", 64'(m_write), 64'(open_p && s_write));
        check("s_waitrequest", 64'(s_waitrequest), 64'(open_p ? m_waitrequest : 1'b1));
        check("m_address", 64'(m_address), 64'(s_address));
        check("m_writedata", 64'(m_writedata), 64'(s_writedata));
        check("s_readdatavalid", 64'(s_readdatavalid), 64'(m_readdatavalid && outst > 0));
        if (s_readdatavalid === 1'b1) begin
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL s_readdata: response delivered with no read owed (t=%0t)", $time);
          end else begin
            exp_d = exp_q.pop_front();
            check("s_readdata", 64'(s_readdata), 64'(exp_d));
          end
        end
        check("freeze_ack", 64'(freeze_ack), 64'(st == S_FROZEN));
        check("timeout_err", 64'(timeout_err), 64'(terr));
        check("stray_rdv_err", 64'(stray_rdv_err), 64'(serr));
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] wd, output int n);
    bit stall;
    s_address = a; s_writedata = wd; s_read = !is_wr; s_write = is_wr; n = 0;
    do begin
      @(negedge clk);
      stall = s_waitrequest;
      step();
      n++;
    end while (stall && n < 100);
    s_read = 1'b0; s_write = 1'b0;
    if (stall) bound_fail("req_accept");
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((outst != 0 || noc_q.size() != 0) && n < 200) begin step(); n++; end
    if (outst != 0 || noc_q.size() != 0) bound_fail("quiet");
    repeat (2) step();
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin step(); n++; end while (freeze_ack !== 1'b1 && n < 60);
    if (freeze_ack !== 1'b1) n = -1;
  endtask

  initial begin : stimulus
    int n;
    int n_acc;
    int n_rdv;
    int t3;
    int ta;
    int pend;
    int frz_left;
    int r;
    bit stall;
    bit hit;

    step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_freeze_ack", 64'(freeze_ack), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    check("rst_stray_err", 64'(stray_rdv_err), 64'd0);
    check("rst_waitrequest", 64'(s_waitrequest), 64'd0);
    step();

    // Pass-through write then read with a fixed NoC response.
    s_address = 20'h00010; s_writedata = 32'h12345678; s_write = 1'b1;
    @(negedge clk);
    check("pt_m_write", 64'(m_write), 64'd1);
    check("pt_m_address", 64'(m_address), 64'h10);
    check("pt_m_writedata", 64'(m_writedata), 64'h12345678);
    step();
    s_write = 1'b0;
    use_fixed = 1'b1; fixed_data = 32'hCAFEF00D; dly_min = 2; dly_max = 2;
    do_req(1'b0, 20'h00010, '0, n);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (s_readdatavalid === 1'b1) begin
        hit = 1'b1;
        check("pt_readdata", 64'(s_readdata), 64'hCAFEF00D);
        check("pt_freeze_ack", 64'(freeze_ack), 64'd0);
      end
    end
    if (!hit) bound_fail("pt_readdatavalid");
    use_fixed = 1'b0; dly_min = 1; dly_max = 3;
    wait_quiet();

    // Outstanding limit: nine reads with responses withheld.
    noc_hold = 1'b1;
    s_read = 1'b1; s_address = 20'h00100; n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      stall = s_waitrequest;
      step();
      if (!stall) begin n_acc++; s_address = s_address + 1'b1; end
    end
    check("lim_accepted", 64'(n_acc), 64'd8);
    @(negedge clk);
    check("lim_waitrequest", 64'(s_waitrequest), 64'd1);
    check("lim_m_read", 64'(m_read), 64'd0);
    noc_hold = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      stall = s_waitrequest;
      step();
      if (!stall) begin hit = 1'b1; n_acc++; end
    end
    s_read = 1'b0;
    check("lim_total", 64'(n_acc), 64'd9);
    wait_quiet();

    // Drain with three reads in flight.
    noc_hold = 1'b1;
    for (int i = 0; i < 3; i++) do_req(1'b0, AW'(20'h00200 + i), '0, n);
    s_write = 1'b1; s_address = 20'h00300; freeze_req = 1'b1;
    @(negedge clk);
    check("freeze_cycle_fwd", 64'(m_write), 64'd1);
    step();
    s_write = 1'b0; s_read = 1'b1;
    @(negedge clk);
    check("drain_m_read", 64'(m_read), 64'd0);
    check("drain_waitrequest", 64'(s_waitrequest), 64'd1);
    step();
    s_read = 1'b0; noc_hold = 1'b0;
    n_rdv = 0; t3 = -100; ta = -1;
    for (int i = 0; i < 40 && ta < 0; i++) begin
      @(negedge clk);
      if (s_readdatavalid === 1'b1) begin n_rdv++; if (n_rdv == 3) t3 = i; end
      if (freeze_ack === 1'b1) ta = i;
    end
    check("drain_rdv_count", 64'(n_rdv), 64'd3);
    check("drain_ack_latency", 64'(ta - t3), 64'd2);
    step();
    freeze_req = 1'b0;
    step();
    do_req(1'b1, 20'h00300, 32'h0BADBEEF, n);
    check("post_drain_write", 64'(n), 64'd1);

    // Idle freeze and unfreeze.
    repeat (3) step();
    freeze_req = 1'b1;
    wait_ack(n);
    check("idle_ack_latency", 64'(n), 64'd2);
    repeat (8) step();
    freeze_req = 1'b0;
    step();
    @(negedge clk);
    check("unfreeze_ack", 64'(freeze_ack), 64'd0);
    do_req(1'b1, 20'h00400, 32'h55AA55AA, n);
    check("unfreeze_write", 64'(n), 64'd1);
    wait_quiet();

    // Drain timeout with one read never answered, then its late response.
    noc_hold = 1'b1;
    do_req(1'b0, 20'h00500, '0, n);
    freeze_req = 1'b1;
    wait_ack(n);
    check("timeout_ack_latency", 64'(n), 64'(TMO + 1));
    @(negedge clk);
    check("timeout_err_set", 64'(timeout_err), 64'd1);
    check("timeout_stray_clear", 64'(stray_rdv_err), 64'd0);
    step();
    noc_hold = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (m_readdatavalid === 1'b1) begin
        hit = 1'b1;
        check("late_rdv_suppressed", 64'(s_readdatavalid), 64'd0);
      end
    end
    if (!hit) bound_fail("late_rdv");
    @(negedge clk);
    check("late_rdv_stray", 64'(stray_rdv_err), 64'd1);
    step();
    freeze_req = 1'b0;
    repeat (2) step();

    // Reset while draining.
    noc_hold = 1'b1;
    do_req(1'b0, 20'h00600, '0, n);
    do_req(1'b0, 20'h00601, '0, n);
    freeze_req = 1'b1;
    repeat (3) step();
    rst = 1'b1; freeze_req = 1'b0;
    step();
    rst = 1'b0; noc_hold = 1'b0;
    @(negedge clk);
    check("rst_drain_ack", 64'(freeze_ack), 64'd0);
    check("rst_drain_timeout", 64'(timeout_err), 64'd0);
    check("rst_drain_stray", 64'(stray_rdv_err), 64'd0);
    check("rst_drain_open", 64'(s_waitrequest), 64'd0);
    step();

    // Randomized traffic with freeze pulses, NoC stalls and occasional stray responses.
    pend = 0; frz_left = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      stall = s_waitrequest;
      step();
      if (pend != 0 && !stall) pend = 0;
      if (pend == 0) begin
        r = int'($urandom_range(99, 0));
        s_address = AW'($urandom());
        s_writedata = DW'($urandom());
        if (r < 40) pend = 1;
        else if (r < 65) pend = 2;
      end
      s_read = (pend == 1);
      s_write = (pend == 2);
      m_waitrequest = ($urandom_range(3, 0) == 0);
      if (frz_left > 0) begin
        frz_left--;
        if (frz_left == 0) freeze_req = 1'b0;
      end else if ($urandom_range(59, 0) == 0) begin
        freeze_req = 1'b1;
        frz_left = int'($urandom_range(30, 3));
      end
      if ($urandom_range(99, 0) == 0) stray_inject = 1'b1;
    end
    s_read = 1'b0; s_write = 1'b0; freeze_req = 1'b0; m_waitrequest = 1'b0;
    wait_quiet();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
